monolith_axis_ip_slave_sif: RTL and testbench
=============================================

# monolith_axis_ip_slave_sif

AXI4-Stream slave front end for the Monolith streaming core: accepts 32-bit words serially from the DMA MM2S channel and packs them into chunks of FIFO_CHUNK_SIZE words, buffered FIFO_CHUNK_COUNT deep. Each complete chunk is presented in parallel to the hash datapath and consumed with a single strobe. It is the inbound counterpart of the chunk-to-stream master interface. The two together bracket the core between DMA channels.

## Interface
- FIFO_CHUNK_SIZE, 16, words per chunk; power of two, ≥2
- FIFO_CHUNK_COUNT, 2, chunk slots; power of two, ≥2
- C_S_AXIS_TDATA_WIDTH, 32, word width
- S_AXIS_ACLK  in  1  single clock, all logic rising-edge
- S_AXIS_ARESET  in  1  reset; asynchronous, active-high
- S_AXIS_TVALID  in  1  word offered
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  word
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  ignored; all bytes treated as data
- S_AXIS_TLAST  in  1  packet boundary
- S_AXIS_TREADY  out  1  slot free, word accepted on TVALID&TREADY
- fifo_out  out  C_S_AXIS_TDATA_WIDTH × FIFO_CHUNK_SIZE (unpacked array)  oldest complete chunk
- fifo_valid  out  1  at least one complete chunk buffered
- fifo_last  out  1  oldest chunk was closed by TLAST
- fifo_read_strobe  in  1  consume oldest chunk; ignored when fifo_valid=0

## Operation
- State: word_idx (log2 SIZE bits), wr_chunk, rd_chunk (log2 COUNT bits, wrap naturally), slots_used (0..COUNT), per-slot words_cnt and last flag.
- S_AXIS_TREADY = !S_AXIS_ARESET && slots_used != FIFO_CHUNK_COUNT. Combinational from registers only; never depends on TVALID.
- Accept (TVALID&TREADY): mem[wr_chunk][word_idx] ← TDATA; word_idx+1.
- Commit when accepted word has word_idx = SIZE−1, or TLAST=1 (with pad feature): store words_cnt = word_idx+1 and last = TLAST, wr_chunk+1, word_idx ← 0, slots_used+1.
- TLAST on word SIZE−1 sets last=1 with full chunk.
- Read: fifo_read_strobe & fifo_valid → rd_chunk+1, slots_used−1.
- Commit and read in the same cycle: slots_used unchanged, both pointers advance.
- fifo_out[i] = mem[rd_chunk][i] if i < words_cnt[rd_chunk], else 0 (zero padding of short chunks).
- fifo_valid = slots_used != 0. fifo_last = last[rd_chunk] & fifo_valid.
- Full: TREADY low until a read. Read in the full cycle raises TREADY the next cycle; there is no same-cycle bypass.
- Reset, async, any time including mid-chunk: word_idx, pointers, slots_used, flags ← 0. Partial chunk discarded. Memory contents not cleared.
- Reset values of outputs: TREADY=0 while reset is asserted, 1 after release. fifo_valid=0, fifo_last=0, fifo_out=0, forced by words_cnt=0.

## Timing
- Final word of chunk accepted at edge N → fifo_valid=1 after edge N (one-cycle latency).
- Sustained throughput: one word per cycle while a slot is free.
- fifo_read_strobe at edge M → next chunk visible after edge M. fifo_out is combinational from rd_chunk.

## Configuration
- MONOLITH_SIF_TLAST_PAD_EN defined: TLAST on a non-final word commits a short chunk, zero-padded, last=1.
- MONOLITH_SIF_TLAST_PAD_EN undefined: TLAST only latched into last; chunks commit solely on word_idx=SIZE−1, and words_cnt is always SIZE.

## Structure
- monolith_sif_pkg: word typedef, chunk typedef (unpacked word array), localparams for chunk/slot address widths. Shared with the master interface.
- One sub-module, monolith_sif_chunk_mem: word-addressed write port ({wr_chunk, word_idx}) and chunk-wide async read port.

## Test plan
(SIZE=16, COUNT=2)
- Stream 16 words 0x1..0x10, TVALID held → fifo_valid rises the cycle after the 16th handshake; fifo_out[0]=0x1, fifo_out[15]=0x10; fifo_last=0.
- Stream 48 words, no reads → TREADY drops after word 32; one strobe → TREADY high next cycle; words 33–48 accepted and form the second buffered chunk.
- PAD_EN: 5 words 0xA..0xE with TLAST on the 5th → chunk with [0..4]=0xA..0xE, [5..15]=0, fifo_last=1. Without PAD_EN the chunk stays pending until 11 more words arrive.
- Strobe coincident with a commit while slots_used=1 → slots_used remains 1, fifo_out shows the next chunk, no word lost.
- Reset asserted after 7 words of a chunk → TREADY=0 and fifo_valid=0 immediately; after release, 16 new words form a clean chunk starting at index 0.
- Random TVALID and strobe gaps over 1000 words, checked against a scoreboard → order preserved, no duplication.

Source files
------------

// File: rtl/monolith_sif_pkg.sv
// Shared types and default geometry for the Monolith stream<->chunk interfaces.
package monolith_sif_pkg;

    localparam int SIF_DATA_W      = 32;
    localparam int SIF_CHUNK_SIZE  = 16;
    localparam int SIF_CHUNK_COUNT = 2;
    localparam int SIF_WORD_AW     = $clog2(SIF_CHUNK_SIZE);
    localparam int SIF_SLOT_AW     = $clog2(SIF_CHUNK_COUNT);

    typedef logic [SIF_DATA_W-1:0] sif_word_t;
    typedef sif_word_t sif_chunk_t [SIF_CHUNK_SIZE];

    // Address width that stays at least one bit wide for degenerate sizes.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/monolith_sif_chunk_mem.sv
// Chunk buffer: word-addressed write port, whole-chunk asynchronous read port.
module monolith_sif_chunk_mem
    import monolith_sif_pkg::*;
#(
    parameter int DATA_W      = SIF_DATA_W,
    parameter int CHUNK_SIZE  = SIF_CHUNK_SIZE,
    parameter int CHUNK_COUNT = SIF_CHUNK_COUNT
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [addr_w(CHUNK_COUNT)-1:0]  wr_chunk,
    input  logic [addr_w(CHUNK_SIZE)-1:0]   wr_word,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic [addr_w(CHUNK_COUNT)-1:0]  rd_chunk,
    output logic [DATA_W-1:0]               rd_data [CHUNK_SIZE]
);

    localparam int WORD_AW = addr_w(CHUNK_SIZE);

    logic [DATA_W-1:0] mem_q [CHUNK_COUNT*CHUNK_SIZE];

    // Storage is deliberately not reset; words_cnt gating hides stale contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[{wr_chunk, wr_word}] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < CHUNK_SIZE; gi++) begin : g_rd
            assign rd_data[gi] = mem_q[{rd_chunk, WORD_AW'(gi)}];
        end
    endgenerate

endmodule

// File: rtl/monolith_axis_ip_slave_sif.sv
// AXI4-Stream slave that packs words into buffered chunks for the hash datapath.
// Optional MONOLITH_SIF_TLAST_PAD_EN: TLAST closes a short, zero-padded chunk.
module monolith_axis_ip_slave_sif
    import monolith_sif_pkg::*;
#(
    parameter int FIFO_CHUNK_SIZE      = SIF_CHUNK_SIZE,
    parameter int FIFO_CHUNK_COUNT     = SIF_CHUNK_COUNT,
    parameter int C_S_AXIS_TDATA_WIDTH = SIF_DATA_W
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic                              S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   fifo_out [FIFO_CHUNK_SIZE],
    output logic                              fifo_valid,
    output logic                              fifo_last,
    input  logic                              fifo_read_strobe
);

    localparam int WORD_AW = addr_w(FIFO_CHUNK_SIZE);
    localparam int SLOT_AW = addr_w(FIFO_CHUNK_COUNT);
    localparam int CNT_W   = $clog2(FIFO_CHUNK_COUNT + 1);
    localparam int WCNT_W  = $clog2(FIFO_CHUNK_SIZE + 1);

    logic [WORD_AW-1:0] word_idx_q, word_idx_d;
    logic [SLOT_AW-1:0] wr_chunk_q, wr_chunk_d;
    logic [SLOT_AW-1:0] rd_chunk_q, rd_chunk_d;
    logic [CNT_W-1:0]   slots_used_q, slots_used_d;
    logic [WCNT_W-1:0]  words_cnt_q [FIFO_CHUNK_COUNT];
    logic [WCNT_W-1:0]  words_cnt_d [FIFO_CHUNK_COUNT];
    logic [FIFO_CHUNK_COUNT-1:0] last_q, last_d;

    logic accept, commit, rd_en, chunk_last;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] rd_data [FIFO_CHUNK_SIZE];
    logic tstrb_unused;

    assign tstrb_unused  = ^S_AXIS_TSTRB;
    assign S_AXIS_TREADY = !S_AXIS_ARESET && (slots_used_q != CNT_W'(FIFO_CHUNK_COUNT));
    assign fifo_valid    = (slots_used_q != '0);
    assign fifo_last     = last_q[rd_chunk_q] & fifo_valid;
    assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;
    assign rd_en         = fifo_read_strobe & fifo_valid;

`ifdef MONOLITH_SIF_TLAST_PAD_EN
    assign commit     = accept && ((word_idx_q == WORD_AW'(FIFO_CHUNK_SIZE - 1)) || S_AXIS_TLAST);
    assign chunk_last = S_AXIS_TLAST;
`else
    // A TLAST seen mid-chunk is remembered until the chunk fills.
    logic pend_last_q, pend_last_d;

    assign commit     = accept && (word_idx_q == WORD_AW'(FIFO_CHUNK_SIZE - 1));
    assign chunk_last = S_AXIS_TLAST | pend_last_q;

    always_comb begin
        pend_last_d = pend_last_q;
        if (commit) begin
            pend_last_d = 1'b0;
        end else if (accept && S_AXIS_TLAST) begin
            pend_last_d = 1'b1;
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            pend_last_q <= 1'b0;
        end else begin
            pend_last_q <= pend_last_d;
        end
    end
`endif

    always_comb begin
        word_idx_d   = word_idx_q;
        wr_chunk_d   = wr_chunk_q;
        rd_chunk_d   = rd_chunk_q;
        slots_used_d = slots_used_q;
        words_cnt_d  = words_cnt_q;
        last_d       = last_q;
        if (accept) begin
            word_idx_d = word_idx_q + 1'b1;
        end
        if (commit) begin
`ifdef MONOLITH_SIF_TLAST_PAD_EN
            words_cnt_d[wr_chunk_q] = WCNT_W'(word_idx_q) + WCNT_W'(1);
`else
            words_cnt_d[wr_chunk_q] = WCNT_W'(FIFO_CHUNK_SIZE);
`endif
            last_d[wr_chunk_q] = chunk_last;
            wr_chunk_d         = wr_chunk_q + 1'b1;
            word_idx_d         = '0;
        end
        if (rd_en) begin
            rd_chunk_d = rd_chunk_q + 1'b1;
        end
        case ({commit, rd_en})
            2'b10:   slots_used_d = slots_used_q + 1'b1;
            2'b01:   slots_used_d = slots_used_q - 1'b1;
            default: slots_used_d = slots_used_q;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            word_idx_q   <= '0;
            wr_chunk_q   <= '0;
            rd_chunk_q   <= '0;
            slots_used_q <= '0;
            last_q       <= '0;
            for (int i = 0; i < FIFO_CHUNK_COUNT; i++) begin
                words_cnt_q[i] <= '0;
            end
        end else begin
            word_idx_q   <= word_idx_d;
            wr_chunk_q   <= wr_chunk_d;
            rd_chunk_q   <= rd_chunk_d;
            slots_used_q <= slots_used_d;
            last_q       <= last_d;
            words_cnt_q  <= words_cnt_d;
        end
    end

    monolith_sif_chunk_mem #(
        .DATA_W      (C_S_AXIS_TDATA_WIDTH),
        .CHUNK_SIZE  (FIFO_CHUNK_SIZE),
        .CHUNK_COUNT (FIFO_CHUNK_COUNT)
    ) u_mem (
        .clk      (S_AXIS_ACLK),
        .we       (accept),
        .wr_chunk (wr_chunk_q),
        .wr_word  (word_idx_q),
        .wr_data  (S_AXIS_TDATA),
        .rd_chunk (rd_chunk_q),
        .rd_data  (rd_data)
    );

    // Words beyond the stored count read as zero; after reset that is every word.
    generate
        for (genvar gi = 0; gi < FIFO_CHUNK_SIZE; gi++) begin : g_out
            assign fifo_out[gi] = (WCNT_W'(gi) < words_cnt_q[rd_chunk_q]) ? rd_data[gi] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_monolith_axis_ip_slave_sif.sv
// Directed and randomized checks of the AXI-Stream chunk packer (SIZE=16, COUNT=2).
module tb_monolith_axis_ip_slave_sif;

    localparam int SIZE  = 16;
    localparam int COUNT = 2;
    localparam int W     = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tvalid = 1'b0;
    logic [W-1:0]   tdata = '0;
    logic [W/8-1:0] tstrb = '1;
    logic           tlast = 1'b0;
    logic           tready;
    logic [W-1:0]   fifo_out [SIZE];
    logic           fifo_valid;
    logic           fifo_last;
    logic           strobe = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    monolith_axis_ip_slave_sif #(
        .FIFO_CHUNK_SIZE      (SIZE),
        .FIFO_CHUNK_COUNT     (COUNT),
        .C_S_AXIS_TDATA_WIDTH (W)
    ) dut (
        .S_AXIS_ACLK      (clk),
        .S_AXIS_ARESET    (rst),
        .S_AXIS_TVALID    (tvalid),
        .S_AXIS_TDATA     (tdata),
        .S_AXIS_TSTRB     (tstrb),
        .S_AXIS_TLAST     (tlast),
        .S_AXIS_TREADY    (tready),
        .fifo_out         (fifo_out),
        .fifo_valid       (fifo_valid),
        .fifo_last        (fifo_last),
        .fifo_read_strobe (strobe)
    );

    // All tasks start and end at a falling edge.
    task automatic send_word(input logic [W-1:0] d, input logic l);
        int n = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        while (tready !== 1'b1 && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        checks++;
        if (tready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout data=%h tready=%b required 1", d, tready);
        end else begin
            @(posedge clk);
            @(negedge clk);
            $display("word %h tlast=%b accepted", d, l);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_range(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) send_word(base + W'(i), 1'b0);
    endtask

    task automatic strobe_once();
        strobe = 1'b1;
        @(posedge clk);
        @(negedge clk);
        strobe = 1'b0;
        $display("strobe issued");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b exp=0", tready); end
        checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", fifo_valid); end
        checks++; if (fifo_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", fifo_last); end
        checks++; if (fifo_out[0] !== 32'h0) begin errors++; $display("FAIL reset_out0 got=%h exp=0", fifo_out[0]); end
        rst = 1'b0;
        #1;
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL release_tready got=%b exp=1", tready); end
        @(negedge clk);
    endtask

    task automatic test_single_chunk();
        send_range(32'h1, 15);
        checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", fifo_valid); end
        send_word(32'h10, 1'b0);
        checks++; if (fifo_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", fifo_valid); end
        checks++; if (fifo_out[0] !== 32'h1) begin errors++; $display("FAIL single_out0 got=%h exp=1", fifo_out[0]); end
        checks++; if (fifo_out[7] !== 32'h8) begin errors++; $display("FAIL single_out7 got=%h exp=8", fifo_out[7]); end
        checks++; if (fifo_out[15] !== 32'h10) begin errors++; $display("FAIL single_out15 got=%h exp=10", fifo_out[15]); end
        checks++; if (fifo_last !== 1'b0) begin errors++; $display("FAIL single_last got=%b exp=0", fifo_last); end
        strobe_once();
        checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", fifo_valid); end
    endtask

    task automatic test_full();
        send_range(32'h101, 32);
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL full_tready got=%b exp=0", tready); end
        checks++; if (fifo_out[0] !== 32'h101) begin errors++; $display("FAIL full_out0 got=%h exp=101", fifo_out[0]); end
        tvalid = 1'b1;
        tdata  = 32'h121;
        strobe = 1'b1;
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%b exp=0", tready); end
        @(posedge clk);
        @(negedge clk);
        strobe = 1'b0;
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL full_reopen got=%b exp=1", tready); end
        checks++; if (fifo_out[0] !== 32'h111) begin errors++; $display("FAIL full_next0 got=%h exp=111", fifo_out[0]); end
        send_range(32'h121, 16);
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL full_again got=%b exp=0", tready); end
        checks++; if (fifo_out[15] !== 32'h120) begin errors++; $display("FAIL full_c2_15 got=%h exp=120", fifo_out[15]); end
        strobe_once();
        checks++; if (fifo_out[0] !== 32'h121) begin errors++; $display("FAIL full_c3_0 got=%h exp=121", fifo_out[0]); end
        checks++; if (fifo_out[15] !== 32'h130) begin errors++; $display("FAIL full_c3_15 got=%h exp=130", fifo_out[15]); end
        strobe_once();
        checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL full_drain got=%b exp=0", fifo_valid); end
    endtask

    task automatic test_tlast();
        send_range(32'hA, 4);
        send_word(32'hE, 1'b1);
`ifdef MONOLITH_SIF_TLAST_PAD_EN
        checks++; if (fifo_valid !== 1'b1) begin errors++; $display("FAIL pad_valid got=%b exp=1", fifo_valid); end
        checks++; if (fifo_last !== 1'b1) begin errors++; $display("FAIL pad_last got=%b exp=1", fifo_last); end
        checks++; if (fifo_out[4] !== 32'hE) begin errors++; $display("FAIL pad_out4 got=%h exp=e", fifo_out[4]); end
        checks++; if (fifo_out[5] !== 32'h0) begin errors++; $display("FAIL pad_out5 got=%h exp=0", fifo_out[5]); end
        checks++; if (fifo_out[15] !== 32'h0) begin errors++; $display("FAIL pad_out15 got=%h exp=0", fifo_out[15]); end
`else
        checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL tlast_pending got=%b exp=0", fifo_valid); end
        send_range(32'hF, 11);
        checks++; if (fifo_valid !== 1'b1) begin errors++; $display("FAIL tlast_valid got=%b exp=1", fifo_valid); end
        checks++; if (fifo_last !== 1'b1) begin errors++; $display("FAIL tlast_last got=%b exp=1", fifo_last); end
        checks++; if (fifo_out[5] !== 32'hF) begin errors++; $display("FAIL tlast_out5 got=%h exp=f", fifo_out[5]); end
        checks++; if (fifo_out[15] !== 32'h19) begin errors++; $display("FAIL tlast_out15 got=%h exp=19", fifo_out[15]); end
`endif
        strobe_once();
        send_range(32'h200, 16);
        checks++; if (fifo_out[0] !== 32'h200) begin errors++; $display("FAIL tlast_next0 got=%h exp=200", fifo_out[0]); end
        checks++; if (fifo_last !== 1'b0) begin errors++; $display("FAIL tlast_next_last got=%b exp=0", fifo_last); end
        strobe_once();
    endtask

    task automatic test_coincident();
        send_range(32'h300, 16);
        send_range(32'h400, 15);
        strobe = 1'b1;
        send_word(32'h40F, 1'b0);
        strobe = 1'b0;
        checks++; if (fifo_valid !== 1'b1) begin errors++; $display("FAIL coin_valid got=%b exp=1", fifo_valid); end
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL coin_tready got=%b exp=1", tready); end
        checks++; if (fifo_out[0] !== 32'h400) begin errors++; $display("FAIL coin_out0 got=%h exp=400", fifo_out[0]); end
        checks++; if (fifo_out[15] !== 32'h40F) begin errors++; $display("FAIL coin_out15 got=%h exp=40f", fifo_out[15]); end
        strobe_once();
        checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL coin_drain got=%b exp=0", fifo_valid); end
    endtask

    task automatic test_reset_mid();
        send_range(32'h500, 16);
        send_range(32'h600, 7);
        #2 rst = 1'b1;
        #1;
        checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rmid_tready got=%b exp=0", tready); end
        checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", fifo_valid); end
        checks++; if (fifo_out[0] !== 32'h0) begin errors++; $display("FAIL rmid_out0 got=%h exp=0", fifo_out[0]); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (tready !== 1'b1) begin errors++; $display("FAIL rmid_release got=%b exp=1", tready); end
        @(negedge clk);
        send_range(32'h700, 16);
        checks++; if (fifo_valid !== 1'b1) begin errors++; $display("FAIL rmid_new_valid got=%b exp=1", fifo_valid); end
        checks++; if (fifo_out[0] !== 32'h700) begin errors++; $display("FAIL rmid_new0 got=%h exp=700", fifo_out[0]); end
        checks++; if (fifo_out[15] !== 32'h70F) begin errors++; $display("FAIL rmid_new15 got=%h exp=70f", fifo_out[15]); end
        strobe_once();
        checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain got=%b exp=0", fifo_valid); end
    endtask

    task automatic test_random();
        int sent = 0;
        int rd_chunks = 0;
        int cyc = 0;
        logic hs;
        logic [W-1:0] exp_w;
        int bad;
        while (rd_chunks < 63 && cyc < 20000) begin
            tvalid = (sent < 63 * SIZE) && ($urandom_range(0, 3) != 0);
            tdata  = 32'h10000 + W'(sent);
            strobe = fifo_valid && ($urandom_range(0, 2) == 0);
            if (strobe) begin
                bad = -1;
                for (int i = SIZE - 1; i >= 0; i--) begin
                    if (fifo_out[i] !== 32'h10000 + W'(rd_chunks * SIZE + i)) bad = i;
                end
                checks++;
                if (bad >= 0) begin
                    errors++;
                    exp_w = 32'h10000 + W'(rd_chunks * SIZE + bad);
                    $display("FAIL random_chunk %0d word %0d got=%h exp=%h", rd_chunks, bad, fifo_out[bad], exp_w);
                end else begin
                    $display("chunk %0d read first=%h", rd_chunks, fifo_out[0]);
                end
                rd_chunks++;
            end
            hs = tvalid & tready;
            @(posedge clk);
            if (hs) sent++;
            @(negedge clk);
            cyc++;
        end
        tvalid = 1'b0;
        strobe = 1'b0;
        checks++; if (rd_chunks != 63) begin errors++; $display("FAIL random_timeout chunks=%0d exp=63", rd_chunks); end
        checks++; if (fifo_valid !== 1'b0) begin errors++; $display("FAIL random_leftover got=%b exp=0", fifo_valid); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_chunk();
        test_full();
        test_tlast();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
